// File: rtl/datapath.sv
// Single-bus 32-bit datapath: general and special registers, a priority bus multiplexer,
// and a 64-bit-result ALU feeding Z.
module datapath (
  input  logic        Clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [4:0]  opcode,
  input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
  input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
  input  logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin,
  input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
  input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
  input  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout,
  input  logic        Inportout, Cout,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut,
  output logic [63:0] Zreg
);

  logic [15:0] r_in, r_out;
  logic [31:0] r_q [16];
  logic [31:0] hi_q, lo_q, y_q, pc_q, ir_q, mar_q, mdr_q, inport_q, c_q;
  logic [63:0] z_q;
  logic [63:0] alu_result;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // Lowest-priority source is assigned first so that higher-priority selects overwrite it.
  always_comb begin
    BusMuxOut = '0;
    if (Cout)      BusMuxOut = c_q;
    if (Inportout) BusMuxOut = inport_q;
    if (MDRout)    BusMuxOut = mdr_q;
    if (MARout)    BusMuxOut = mar_q;
    if (IRout)     BusMuxOut = ir_q;
    if (PCout)     BusMuxOut = pc_q;
    if (Zlowout)   BusMuxOut = z_q[31:0];
    if (Zhighout)  BusMuxOut = z_q[63:32];
    if (Yout)      BusMuxOut = y_q;
    if (LOout)     BusMuxOut = lo_q;
    if (HIout)     BusMuxOut = hi_q;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) BusMuxOut = r_q[i];
    end
  end

  logic [31:0]        op_a, op_b, sra_res, ror_res, rol_res;
  logic [4:0]         shamt;
  logic [63:0]        rot_src;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;

  always_comb begin
    op_a    = y_q;
    op_b    = BusMuxOut;
    shamt   = op_b[4:0];
    rot_src = {op_a, op_a};
    sra_res = $unsigned($signed(op_a) >>> shamt);
    ror_res = 32'(rot_src >> shamt);
    // Left rotate by s equals right rotate by 32-s; s=0 shifts by 32, giving op_a back.
    rol_res = 32'(rot_src >> (6'd32 - {1'b0, shamt}));
    prod    = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    quo     = '0;
    rem     = '0;
    if (op_b != 32'd0) begin
      quo = $signed(op_a) / $signed(op_b);
      rem = $signed(op_a) % $signed(op_b);
    end
    alu_result = '0;
    if (IncPC) begin
      alu_result = {32'd0, op_b + 32'd1};
    end else begin
      case (opcode)
        5'b00011: alu_result = {32'd0, op_a + op_b};
        5'b00100: alu_result = {32'd0, op_a - op_b};
        5'b00101: alu_result = {32'd0, op_a & op_b};
        5'b00110: alu_result = {32'd0, op_a | op_b};
        5'b00111: alu_result = {32'd0, op_a >> shamt};
        5'b01000: alu_result = {32'd0, sra_res};
        5'b01001: alu_result = {32'd0, op_a << shamt};
        5'b01010: alu_result = {32'd0, ror_res};
        5'b01011: alu_result = {32'd0, rol_res};
        5'b01100: alu_result = prod;
        5'b01101: alu_result = {rem, quo};
        5'b01110: alu_result = {32'd0, -op_b};
        5'b01111: alu_result = {32'd0, ~op_b};
        default:  alu_result = '0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      y_q      <= '0;
      pc_q     <= '0;
      ir_q     <= '0;
      mar_q    <= '0;
      mdr_q    <= '0;
      inport_q <= '0;
      c_q      <= '0;
      z_q      <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) r_q[i] <= BusMuxOut;
      end
      if (HIin)     hi_q     <= BusMuxOut;
      if (LOin)     lo_q     <= BusMuxOut;
      if (Yin)      y_q      <= BusMuxOut;
      if (PCin)     pc_q     <= BusMuxOut;
      if (IRin)     ir_q     <= BusMuxOut;
      if (MARin)    mar_q    <= BusMuxOut;
      if (MDRin)    mdr_q    <= Read ? Mdatain : BusMuxOut;
      if (Inportin) inport_q <= BusMuxOut;
      if (Cin)      c_q      <= {{13{ir_q[18]}}, ir_q[18:0]};
      if (Zin)      z_q      <= alu_result;
    end
  end

  assign Zreg = z_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: register transfers, fetch, ALU ops, bus priority and reset.
module tb_datapath;

  logic        Clock = 1'b0;
  logic        clear, Read, IncPC;
  logic [4:0]  opcode;
  logic [15:0] rin, rout;
  logic        HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin, Inportin, Cin;
  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout;
  logic        Inportout, Cout;
  logic [31:0] Mdatain;
  logic [31:0] BusMuxOut;
  logic [63:0] Zreg;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  datapath dut (
    .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zin(Zin), .PCin(PCin), .IRin(IRin),
    .MARin(MARin), .MDRin(MDRin), .Inportin(Inportin), .Cin(Cin),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .IRout(IRout), .MARout(MARout), .MDRout(MDRout),
    .Inportout(Inportout), .Cout(Cout),
    .Mdatain(Mdatain), .BusMuxOut(BusMuxOut), .Zreg(Zreg)
  );

  task automatic idle();
    clear = 1'b1; Read = 1'b0; IncPC = 1'b0; opcode = 5'd0; rin = '0; rout = '0;
    HIin = 0; LOin = 0; Yin = 0; Zin = 0; PCin = 0; IRin = 0; MARin = 0; MDRin = 0;
    Inportin = 0; Cin = 0;
    HIout = 0; LOout = 0; Yout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; IRout = 0;
    MARout = 0; MDRout = 0; Inportout = 0; Cout = 0;
  endtask

  // One rising edge, then controls return to idle.
  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1'b1; MDRin = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    Mdatain = '0;
    clear = 1'b0;
    tick();
    chk("reset_z", Zreg, 64'd0);
    #1 chk("bus_idle", {32'd0, BusMuxOut}, 64'd0);
    rout[1] = 1'b1;
    #1 chk("reset_r1", {32'd0, BusMuxOut}, 64'd0);

    // Register loads through MDR
    load_mdr(32'd4); MDRout = 1; rin[2] = 1; tick();
    load_mdr(32'd5); MDRout = 1; rin[3] = 1; tick();
    load_mdr(32'd8); MDRout = 1; rin[1] = 1; tick();
    rout[2] = 1; #1 chk("r2_load", {32'd0, BusMuxOut}, 64'd4);
    idle(); rout[3] = 1; #1 chk("r3_load", {32'd0, BusMuxOut}, 64'd5);
    idle(); rout[1] = 1; #1 chk("r1_load", {32'd0, BusMuxOut}, 64'd8);
    idle();

    // Fetch
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; tick();
    chk("fetch_z", Zreg, 64'd1);
    MARout = 1; #1 chk("fetch_mar", {32'd0, BusMuxOut}, 64'd0);
    idle(); Zlowout = 1; PCin = 1; tick();
    PCout = 1; #1 chk("fetch_pc", {32'd0, BusMuxOut}, 64'd1);
    idle();
    load_mdr(32'h1891_8000); MDRout = 1; IRin = 1; tick();
    IRout = 1; #1 chk("fetch_ir", {32'd0, BusMuxOut}, 64'h1891_8000);
    idle(); Cin = 1; tick();
    Cout = 1; #1 chk("c_sext_pos", {32'd0, BusMuxOut}, 64'h0001_8000);
    idle();

    // add R1 = R2 + R3
    rout[2] = 1; Yin = 1; tick();
    rout[3] = 1; opcode = 5'b00011; Zin = 1; tick();
    chk("add_z", Zreg, 64'd9);
    Zlowout = 1; rin[1] = 1; tick();
    rout[1] = 1; #1 chk("add_r1", {32'd0, BusMuxOut}, 64'd9);
    idle();

    // sub 4 - 5 (Y still holds 4)
    rout[3] = 1; opcode = 5'b00100; Zin = 1; tick();
    chk("sub_wrap", Zreg, 64'h0000_0000_FFFF_FFFF);

    // mul -1 * 2
    load_mdr(32'd2); MDRout = 1; rin[4] = 1; tick();
    load_mdr(32'hFFFF_FFFF); MDRout = 1; Yin = 1; tick();
    rout[4] = 1; opcode = 5'b01100; Zin = 1; tick();
    chk("mul_neg", Zreg, 64'hFFFF_FFFF_FFFF_FFFE);
    Zhighout = 1; #1 chk("zhigh_bus", {32'd0, BusMuxOut}, 64'hFFFF_FFFF);
    idle();

    // div 7 / 2, then divide by zero (idle bus)
    load_mdr(32'd7); MDRout = 1; Yin = 1; tick();
    rout[4] = 1; opcode = 5'b01101; Zin = 1; tick();
    chk("div_7_2", Zreg, 64'h0000_0001_0000_0003);
    opcode = 5'b01101; Zin = 1; tick();
    chk("div_by_0", Zreg, 64'd0);

    // Shifts and rotates with Y = 7
    rout[3] = 1; opcode = 5'b01001; Zin = 1; tick();
    chk("shl_5", Zreg, 64'h0000_00E0);
    rout[4] = 1; opcode = 5'b01010; Zin = 1; tick();
    chk("ror_2", Zreg, 64'h0000_0000_C000_0001);
    rout[4] = 1; opcode = 5'b01011; Zin = 1; tick();
    chk("rol_2", Zreg, 64'h0000_001C);

    // IncPC overrides add: R1 (9) + 1 instead of Y + R1
    rout[1] = 1; opcode = 5'b00011; IncPC = 1; Zin = 1; tick();
    chk("incpc_override", Zreg, 64'd10);

    // Unassigned opcode yields 0
    rout[1] = 1; opcode = 5'b11111; Zin = 1; tick();
    chk("bad_opcode", Zreg, 64'd0);

    // Bus priority: R2 over MDR, R1 over R2, HI over Cout
    rout[2] = 1; MDRout = 1; #1 chk("prio_r2_mdr", {32'd0, BusMuxOut}, 64'd4);
    rout[1] = 1; #1 chk("prio_r1_r2", {32'd0, BusMuxOut}, 64'd9);
    idle(); HIout = 1; Cout = 1; #1 chk("prio_hi_c", {32'd0, BusMuxOut}, 64'd0);
    idle();

    // Reset beats load enables in the same cycle
    rout[3] = 1; Zin = 1; opcode = 5'b00011; tick();
    clear = 0; rin[1] = 1; MDRout = 1; tick();
    rout[1] = 1; #1 chk("clear_r1", {32'd0, BusMuxOut}, 64'd0);
    idle(); MDRout = 1; #1 chk("clear_mdr", {32'd0, BusMuxOut}, 64'd0);
    idle(); rout[2] = 1; #1 chk("clear_r2", {32'd0, BusMuxOut}, 64'd0);
    idle(); chk("clear_z", Zreg, 64'd0);
    #1 chk("bus_idle_end", {32'd0, BusMuxOut}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
